// File: rtl/ahb_master_ctrl_if.sv
// Command, write/read-data and AHB-Lite bus signals of ahb_master_ctrl.
// The master modport is the controller's view; the slave modport is everything facing it.
interface ahb_master_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        done_err;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, hready, hresp, hrdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, done, done_err,
           htrans, haddr, hwrite, hsize, hburst, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, hready, hresp, hrdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done, done_err,
           htrans, haddr, hwrite, hsize, hburst, hwdata
  );
endinterface

// File: rtl/ahb_master_ctrl.sv
// AHB-Lite burst master: one command -> up to MAX_LEN word beats, done pulse N+2 cycles after accept.
// Write beats wait on wr_valid (BUSY/IDLE inserted); reads have no backpressure; slave stalls via hready.
module ahb_master_ctrl #(
  parameter int MAX_LEN = 16
) (
  input logic               hclk,
  input logic               hreset,
  ahb_master_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [4:0] LEN_MAX   = 5'(MAX_LEN);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_write;
  logic        r_incr;
  logic        r_first;
  logic        r_nonseq;
  logic        r_dp;
  logic        r_done;
  logic        r_done_err;
  logic [31:0] r_addr;
  logic [31:0] r_hwdata;
  logic [4:0]  r_remain;

  logic        w_resp_err;
  logic        w_dp_err;
  logic        w_beat_rdy;
  logic        w_cmd_rdy;
  logic        w_cmd_go;
  logic        w_addr_go;
  logic        w_dp_ok;
  logic [4:0]  w_len_eff;
  logic [31:0] w_addr_inc;
  logic [1:0]  w_htrans;
  logic        w_done_set;
  logic        w_err_set;

  assign w_resp_err = (bus.hresp != RESP_OKAY);
  assign w_dp_err   = r_dp && w_resp_err;
  assign w_beat_rdy = !r_write || bus.wr_valid;
  // The done cycle is excluded so a back-to-back command lands one cycle later.
  assign w_cmd_rdy  = (r_state == S_IDLE) && !r_done && !hreset;
  assign w_cmd_go   = bus.cmd_valid && w_cmd_rdy;
  assign w_len_eff  = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;
  assign w_addr_go  = (r_state == S_ADDR) && w_beat_rdy && bus.hready && !w_dp_err;
  assign w_dp_ok    = r_dp && bus.hready && !w_resp_err &&
                      ((r_state == S_ADDR) || (r_state == S_DATA));
  assign w_addr_inc = r_addr + 32'd4;

  always_comb begin
    w_state_nxt = r_state;
    w_htrans    = HT_IDLE;
    w_done_set  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_go) begin
          if (bus.cmd_len == 5'd0) begin
            w_done_set = 1'b1;
            w_err_set  = 1'b1;
          end else begin
            w_state_nxt = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        // An ERROR response cancels the pending address phase in the same cycle.
        if (w_dp_err) begin
          if (bus.hready) begin
            w_done_set  = 1'b1;
            w_err_set   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_ERR;
          end
        end else begin
          if (!w_beat_rdy) w_htrans = r_first ? HT_IDLE : HT_BUSY;
          else             w_htrans = r_nonseq ? HT_NONSEQ : HT_SEQ;
          if (w_addr_go && (r_remain == 5'd1)) w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.hready) begin
          w_done_set  = 1'b1;
          w_err_set   = w_resp_err;
          w_state_nxt = S_IDLE;
        end else if (w_resp_err) begin
          w_state_nxt = S_ERR;
        end
      end
      S_ERR: begin
        if (bus.hready) begin
          w_done_set  = 1'b1;
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_incr     <= 1'b0;
      r_first    <= 1'b0;
      r_nonseq   <= 1'b0;
      r_dp       <= 1'b0;
      r_done     <= 1'b0;
      r_done_err <= 1'b0;
      r_addr     <= 32'd0;
      r_hwdata   <= 32'd0;
      r_remain   <= 5'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= w_done_set;
      r_done_err <= w_err_set;
      if (w_cmd_go) begin
        r_write  <= bus.cmd_write;
        r_addr   <= bus.cmd_addr & 32'hFFFF_FFFC;
        r_remain <= w_len_eff;
        r_incr   <= (w_len_eff > 5'd1);
        r_first  <= 1'b1;
        r_nonseq <= 1'b1;
        r_dp     <= 1'b0;
      end else if (w_addr_go) begin
        r_addr   <= w_addr_inc;
        r_remain <= r_remain - 5'd1;
        r_first  <= 1'b0;
        // Crossing a 1 KB boundary restarts the burst with NONSEQ.
        r_nonseq <= (w_addr_inc[9:0] == 10'd0);
        r_dp     <= 1'b1;
        if (r_write) r_hwdata <= bus.wr_data;
      end else if (w_dp_ok || (w_state_nxt == S_IDLE)) begin
        r_dp     <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = w_cmd_rdy;
  assign bus.wr_ready  = w_addr_go && r_write;
  assign bus.rd_valid  = w_dp_ok && !r_write;
  assign bus.rd_data   = bus.hrdata;
  assign bus.done      = r_done;
  assign bus.done_err  = r_done_err;
  assign bus.htrans    = w_htrans;
  assign bus.haddr     = r_addr;
  assign bus.hwrite    = r_write;
  assign bus.hsize     = 3'b010;
  assign bus.hburst    = {2'b00, r_incr};
  assign bus.hwdata    = r_hwdata;

endmodule

// File: doc/ahb_master_ctrl.md
AHB_MASTER_CTRL -- requirements
Module: ahb_master_ctrl

Interface
REQ-001 Parameter: MAX_LEN, 16, maximum beats per command (power of two, 2..16).
REQ-002 Port: hclk  in  1  sole clock; all logic on its rising edge.
REQ-003 Port: hreset  in  1  reset, asynchronous, active-high.
REQ-004 Port: cmd_valid  in  1  command offered.
REQ-005 Port: cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-006 Port: cmd_write  in  1  1 = write, 0 = read.
REQ-007 Port: cmd_addr  in  32  start byte address; bits [1:0] ignored (forced 0).
REQ-008 Port: cmd_len  in  5  beat count, 1..MAX_LEN; 0 is illegal.
REQ-009 Port: wr_valid / wr_ready / wr_data  in / out / in  1/1/32  write-data handshake, one word per beat.
REQ-010 Port: rd_valid / rd_data  out / out  1/32  read-data pulse, no backpressure.
REQ-011 Port: done / done_err  out / out  1/1  one-cycle completion pulse; done_err qualifies it.
REQ-012 Port: htrans[1:0], haddr[31:0], hwrite, hsize[2:0], hburst[2:0], hwdata[31:0]  out  AHB-Lite master signals.
REQ-013 Port: hready  in  1, hresp  in  2, hrdata  in  32  AHB slave response (OKAY=00, ERROR=01).

Function
REQ-014 States: IDLE, ADDR (address phases issuing), DATA (last data phase outstanding), ERR (second ERROR cycle).
REQ-015 cmd_ready = 1 only in IDLE; acceptance latches write flag, aligned address, length; moves to ADDR next cycle.
REQ-016 hsize is always 3'b010 (word); hburst = SINGLE (000) if cmd_len==1, else INCR (001).
REQ-017 First beat and every beat after a 1 KB boundary crossing are NONSEQ (10); other beats SEQ (11); haddr increments by 4 per accepted address phase.
REQ-018 An address phase is accepted on a cycle with hready=1 and htrans NONSEQ/SEQ; htrans, haddr, hwrite, hburst hold stable while hready=0.
REQ-019 Write: a beat's address phase is driven only when wr_valid=1; wr_ready pulses on the accepting cycle and wr_data is registered then, driven on hwdata through the following data phase until hready=1.
REQ-020 Write, wr_valid=0 mid-burst: drive htrans BUSY (01) with the next address held; before the first beat: drive IDLE (00).
REQ-021 Read: on every cycle in a read data phase with hready=1 and hresp=OKAY, rd_valid=1 and rd_data=hrdata.
REQ-022 After the last address phase is accepted, htrans=IDLE and state DATA; when that data phase completes OKAY: done=1, done_err=0, return to IDLE.
REQ-023 Minimum latency, zero-wait slave: 1-beat read done pulses 3 cycles after command acceptance; N beats -> N+2 cycles.
REQ-024 hresp=ERROR with hready=0: master drives htrans=IDLE that same cycle (cancels any pending address phase), enters ERR; on the following hready=1: done=1, done_err=1, no rd_valid, IDLE.
REQ-025 Remaining beats after ERROR are discarded; no further wr_ready pulses for that command.
REQ-026 cmd_len==0: accepted, no bus activity, done=1 with done_err=1 on the next cycle.
REQ-027 cmd_len>MAX_LEN: treated as MAX_LEN.
REQ-028 A new command is not accepted in the cycle done pulses; earliest acceptance is the following cycle.

Reset
REQ-029 While hreset=1: state IDLE, htrans=00, haddr=0, hwrite=0, hsize=3'b010, hburst=000, hwdata=0, cmd_ready=0, wr_ready=0, rd_valid=0, done=0, done_err=0.
REQ-030 Reset asserted mid-burst aborts immediately with no done pulse; cmd_ready=1 on the first cycle after release.

Verification
REQ-031 Read cmd_addr=0x100, len=4, zero-wait slave -> haddr 0x100 NONSEQ, 0x104/0x108/0x10C SEQ, hburst=INCR, 4 rd_valid, done_err=0, done 6 cycles after acceptance.
REQ-032 Write cmd_addr=0x3F8, len=4 -> haddr 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ; hwdata matches wr_data order.
REQ-033 Write len=3, wr_valid low 2 cycles before beat 2 -> two BUSY cycles with haddr held, then SEQ; 3 wr_ready pulses total.
REQ-034 Read len=2, slave inserts 2 wait states on beat 1 -> address/control stable during waits, rd_data = hrdata sampled at hready=1.
REQ-035 Write len=4, slave ERROR on beat 2 -> htrans=IDLE during first ERROR cycle, done=1 with done_err=1, exactly 2 wr_ready pulses.
REQ-036 hreset pulsed during beat 3 of len=8 read -> all outputs at reset values, no done; next command executes normally.
